// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the execute stage and a word-only data memory.
// Optional `LSU_ALIGN_CHECK_EN: report misaligned accesses as errors instead of forcing alignment.
module lsu_dmem_ctrl #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal_f3, out_of_range, req_err;
  logic [31:0] acc_addr;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_mask, lane_data;

  // Request decode: funct3 legality, range, alignment policy.
  always_comb begin
    legal_f3     = req_we ? (req_funct3 <= 3'd2)
                          : (req_funct3 != 3'd3 && req_funct3 != 3'd6 && req_funct3 != 3'd7);
    out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    acc_addr     = req_addr;
`ifdef LSU_ALIGN_CHECK_EN
    req_err = !legal_f3 || out_of_range ||
              (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
              (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`else
    req_err = !legal_f3 || out_of_range;
    if (req_funct3[1:0] == 2'd1)      acc_addr[0]   = 1'b0;
    else if (req_funct3[1:0] == 2'd2) acc_addr[1:0] = 2'b00;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) begin
        if (req_err)                     state_d = RESP;
        else if (!req_we)                state_d = RD;
        else if (req_funct3[1:0] == 2'd2) state_d = WR;
        else                             state_d = RMW_RD;
      end
      RD:      state_d = RESP;
      RMW_RD:  state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and merge mask for read-modify-write stores.
  always_comb begin
    lane_b = 8'(mem_rd >> {addr_q[1:0], 3'b000});
    lane_h = 16'(mem_rd >> {addr_q[1], 4'b0000});
    if (f3_q[0]) begin
      lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      lane_data = wdata_q << {addr_q[1], 4'b0000};
    end else begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      lane_data = wdata_q << {addr_q[1:0], 3'b000};
    end
  end

  always_comb begin
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    mem_wd_d = mem_wd_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        f3_d    = req_funct3;
        err_d   = req_err;
        rdata_d = 32'h0;
        if (!req_err) begin
          addr_d  = acc_addr;
          wdata_d = req_wdata;
          if (req_we && req_funct3[1:0] == 2'd2) mem_wd_d = req_wdata;
        end
      end
      RD: begin
        unique case (f3_q)
          3'd0:    rdata_d = {{24{lane_b[7]}}, lane_b};
          3'd1:    rdata_d = {{16{lane_h[15]}}, lane_h};
          3'd4:    rdata_d = {24'h0, lane_b};
          3'd5:    rdata_d = {16'h0, lane_h};
          default: rdata_d = mem_rd;
        endcase
      end
      RMW_RD:  mem_wd_d = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      mem_wd_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      mem_wd_q <= mem_wd_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    busy       = state_q != IDLE;
    resp_valid = state_q == RESP;
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = rdata_q;
    mem_we     = state_q == WR;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wd     = mem_wd_q;
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed plan cases plus random traffic
// against a byte-level memory model.
module tb_lsu_dmem_ctrl;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        load_pattern = 1'b0;

  int errors = 0;
  int checks = 0;

  lsu_dmem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr[31:12] == 20'd0) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (load_pattern) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
    end else if (mem_we && mem_addr[31:12] == 20'd0) begin
      mem[mem_addr[11:2]] <= mem_wd;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: byte-granular view of the access, updates ref_mem for stores.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic e_err,
                                output logic [31:0] e_rd, output int e_lat, output int e_we);
    int unsigned size, a, pos;
    logic        legal, mis;
    logic [31:0] word, v;
    size  = 32'd1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a     = addr;
    mis   = (a % size) != 0;
    e_err = !legal || (a / 4 >= MEM_WORDS);
`ifdef LSU_ALIGN_CHECK_EN
    if (mis) e_err = 1'b1;
`else
    if (mis) a = a - (a % size);
`endif
    e_rd = 32'h0;
    e_we = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      word = ref_mem[a / 4];
      v    = word >> (8 * (a % 4));
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      e_rd  = v;
      e_lat = 2;
    end else begin
      word = ref_mem[a / 4];
      for (int unsigned i = 0; i < size; i++) begin
        pos = (a % 4) + i;
        word[8*pos +: 8] = wd[8*i +: 8];
      end
      ref_mem[a / 4] = word;
      e_we  = 1;
      e_lat = (size == 4) ? 2 : 3;
    end
  endfunction

  // Issues one request from IDLE and observes it until one cycle after the response.
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] rdata, output int we_cnt, output logic shape_ok);
    lat = 0; err = 1'b0; rdata = 32'h0; we_cnt = 0; shape_ok = 1'b1;
    @(negedge clk);
    req = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (mem_addr[1:0] != 2'b00 || busy !== 1'b1) shape_ok = 1'b0;
      if (resp_valid) begin
        lat = n; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    @(negedge clk);
    if (resp_valid !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) shape_ok = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899_AABB;
    load_pattern = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_pattern = 1'b0;
    checks++;
    if ({busy, resp_valid, resp_err, mem_we} !== 4'b0 || mem_addr !== 32'h0 ||
        mem_wd !== 32'h0 || resp_rdata !== 32'h0)
      $display("FAIL reset_outputs: busy=%b rv=%b err=%b we=%b addr=%h wd=%h rd=%h, required all zero",
               busy, resp_valid, resp_err, mem_we, mem_addr, mem_wd, resp_rdata);
    else errors += 0;
    if (checks > 0 && ({busy, resp_valid, resp_err, mem_we} !== 4'b0 || mem_addr !== 32'h0 ||
        mem_wd !== 32'h0 || resp_rdata !== 32'h0)) errors++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_byte_loads();
    int lat, wc; logic err, ok; logic [31:0] rd;
    drive_req(1'b0, 3'd0, 32'h11, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (rd !== 32'hFFFF_FFAA || err !== 1'b0) begin
      errors++; $display("FAIL lb_sext: rdata=%h err=%b, required ffffffaa err=0", rd, err);
    end
    checks++;
    if (lat != 2 || !ok || wc != 0) begin
      errors++; $display("FAIL lb_timing: latency=%0d shape_ok=%b we_cycles=%0d, required 2/1/0", lat, ok, wc);
    end
    drive_req(1'b0, 3'd4, 32'h11, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (rd !== 32'h0000_00AA || lat != 2 || !ok) begin
      errors++; $display("FAIL lbu_zext: rdata=%h latency=%0d, required 000000aa latency 2", rd, lat);
    end
  endtask

  task automatic test_sub_word_stores();
    int lat, wc, e_lat, e_we; logic err, ok, e_err; logic [31:0] rd, e_rd;
    model(1'b1, 3'd0, 32'h12, 32'h1234_5677, e_err, e_rd, e_lat, e_we);
    drive_req(1'b1, 3'd0, 32'h12, 32'h1234_5677, lat, err, rd, wc, ok);
    checks++;
    if (mem[4] !== 32'h8877_AABB) begin
      errors++; $display("FAIL sb_merge: word=%h, required 8877aabb", mem[4]);
    end
    checks++;
    if (lat != 3 || wc != 1 || err !== 1'b0 || rd !== 32'h0 || !ok) begin
      errors++; $display("FAIL sb_timing: latency=%0d we_cycles=%0d err=%b rdata=%h, required 3/1/0/0", lat, wc, err, rd);
    end
    model(1'b1, 3'd1, 32'h12, 32'h0000_CAFE, e_err, e_rd, e_lat, e_we);
    drive_req(1'b1, 3'd1, 32'h12, 32'h0000_CAFE, lat, err, rd, wc, ok);
    checks++;
    if (mem[4] !== 32'hCAFE_AABB || lat != 3 || wc != 1) begin
      errors++; $display("FAIL sh_merge: word=%h latency=%0d, required cafeaabb latency 3", mem[4], lat);
    end
    drive_req(1'b0, 3'd5, 32'h12, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (rd !== 32'h0000_CAFE) begin
      errors++; $display("FAIL lhu: rdata=%h, required 0000cafe", rd);
    end
    drive_req(1'b0, 3'd1, 32'h12, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (rd !== 32'hFFFF_CAFE) begin
      errors++; $display("FAIL lh: rdata=%h, required ffffcafe", rd);
    end
  endtask

  task automatic test_misaligned();
    int lat, wc; logic err, ok; logic [31:0] rd;
    drive_req(1'b0, 3'd2, 32'h13, 32'h0, lat, err, rd, wc, ok);
    checks++;
`ifdef LSU_ALIGN_CHECK_EN
    if (err !== 1'b1 || rd !== 32'h0 || wc != 0 || lat != 1) begin
      errors++; $display("FAIL lw_misaligned: err=%b rdata=%h we_cycles=%0d latency=%0d, required 1/0/0/1", err, rd, wc, lat);
    end
`else
    if (err !== 1'b0 || rd !== 32'hCAFE_AABB || lat != 2) begin
      errors++; $display("FAIL lw_misaligned: err=%b rdata=%h latency=%0d, required 0/cafeaabb/2", err, rd, lat);
    end
`endif
  endtask

  task automatic test_errors();
    int lat, wc; logic err, ok; logic [31:0] rd;
    drive_req(1'b0, 3'd2, 32'h1000, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat != 1) begin
      errors++; $display("FAIL range_err: err=%b rdata=%h latency=%0d, required 1/0/1", err, rd, lat);
    end
    drive_req(1'b0, 3'd3, 32'h10, 32'h0, lat, err, rd, wc, ok);
    checks++;
    if (err !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL load_f3_err: err=%b latency=%0d, required 1/1", err, lat);
    end
    drive_req(1'b1, 3'd4, 32'h10, 32'h5555_5555, lat, err, rd, wc, ok);
    checks++;
    if (err !== 1'b1 || wc != 0 || mem[4] !== 32'hCAFE_AABB) begin
      errors++; $display("FAIL store_f3_err: err=%b we_cycles=%0d word=%h, required 1/0/cafeaabb", err, wc, mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic ea, eb; logic [31:0] ra, rb; int la, lb, wa, wb;
    model(1'b0, 3'd2, 32'h10, 32'h0, ea, ra, la, wa);
    model(1'b0, 3'd4, 32'h12, 32'h0, eb, rb, lb, wb);
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk);
    #1 req_funct3 = 3'd4; req_addr = 32'h12;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== ra) begin
      errors++; $display("FAIL b2b_first: rv=%b rdata=%h, required 1/%h", resp_valid, resp_rdata, ra);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: busy=%b rv=%b, required 0/0", busy, resp_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== rb) begin
      errors++; $display("FAIL b2b_second: rv=%b rdata=%h, required 1/%h", resp_valid, resp_rdata, rb);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++; $display("FAIL sw_in_wr: mem_we=%b, required 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid, resp_err, mem_we} !== 4'b0 || mem_addr !== 32'h0 ||
        mem_wd !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_in_wr: busy=%b rv=%b we=%b addr=%h wd=%h, required all zero",
                         busy, resp_valid, mem_we, mem_addr, mem_wd);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++;
    if (seen || mem[8] !== ref_mem[8]) begin
      errors++; $display("FAIL reset_abandon: resp_seen=%b word=%h, required 0/%h", seen, mem[8], ref_mem[8]);
    end
  endtask

  task automatic test_random();
    int lat, wc, e_lat, e_we, bad; logic err, ok, e_err, we; logic [31:0] rd, e_rd, addr, wd;
    logic [2:0] f3;
    for (int it = 0; it < 120; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + $urandom_range(0, 255);
        1:       addr = $urandom;
        default: addr = $urandom_range(0, 255);
      endcase
      wd = $urandom;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_we);
      drive_req(we, f3, addr, wd, lat, err, rd, wc, ok);
      checks++;
      if (err !== e_err || rd !== e_rd || lat != e_lat || wc != e_we || !ok) begin
        errors++;
        $display("FAIL rand_%0d: we=%b f3=%0d addr=%h got err=%b rdata=%h lat=%0d we=%0d ok=%b, required err=%b rdata=%h lat=%0d we=%0d",
                 it, we, f3, addr, err, rd, lat, wc, ok, e_err, e_rd, e_lat, e_we);
      end
    end
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) $display("FAIL rand_memory: word %0d=%h, required %h", i, mem[i], ref_mem[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_sub_word_stores();
    test_misaligned();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
